// File: rtl/connect4_pkg.sv
// Connect-4 board geometry, cell/direction/state encodings and board lookup helpers
// shared by the win scanner and its line matcher.
package connect4_pkg;

    localparam int unsigned ROWS     = 6;
    localparam int unsigned COLS     = 7;
    localparam int unsigned WIN_LEN  = 4;
    localparam int unsigned CELLS    = ROWS * COLS;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned RC_W     = 3;
    localparam int unsigned NUM_DIRS = 4;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_P1    = 2'd1,
        CELL_P2    = 2'd2,
        CELL_BAD   = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        DIR_H  = 2'd0,
        DIR_V  = 2'd1,
        DIR_D  = 2'd2,
        DIR_AD = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

    // Row step for a scan direction.
    function automatic int dir_dr(int d);
        return (d == int'(DIR_H)) ? 0 : 1;
    endfunction

    // Column step for a scan direction (anti-diagonal walks left).
    function automatic int dir_dc(int d);
        if (d == int'(DIR_V))       return 0;
        else if (d == int'(DIR_AD)) return -1;
        else                        return 1;
    endfunction

    function automatic logic in_board(int r, int c);
        return (r >= 0) && (r < int'(ROWS)) && (c >= 0) && (c < int'(COLS));
    endfunction

    // Off-board positions read as CELL_BAD so they can never complete a line.
    function automatic logic [1:0] cell_at(board_t b, int r, int c);
        if (!in_board(r, c)) return 2'(CELL_BAD);
        return b[RC_W'(r)][RC_W'(c)];
    endfunction

endpackage

// File: rtl/c4_line_match.sv
// Combinational check of one candidate line of four cells.
// Ports: cell0..cell3 - cell codes along the line; valid - line lies inside the board;
//        match_c - all four equal and owned by a player; code_c - owning player code or 0.
module c4_line_match
    import connect4_pkg::*;
(
    input  logic [1:0] cell0,
    input  logic [1:0] cell1,
    input  logic [1:0] cell2,
    input  logic [1:0] cell3,
    input  logic       valid,
    output logic       match_c,
    output logic [1:0] code_c
);

    logic same;
    logic owned;

    assign same    = (cell0 == cell1) && (cell1 == cell2) && (cell2 == cell3);
    assign owned   = (cell0 == 2'(CELL_P1)) || (cell0 == 2'(CELL_P2));
    assign match_c = valid && same && owned;
    assign code_c  = match_c ? cell0 : 2'(CELL_EMPTY);

endmodule

// File: rtl/c4_win_scanner.sv
// Sequential Connect-4 win/draw scanner: snapshots the board on start and tests one
// anchor cell per clock in all four directions, reporting the first line found or a draw.
// Ports: clk, reset_n (sync, active-low); start - scan request; board - live board;
//        busy - scan running; done - one-cycle result strobe; win/winner/draw - result;
//        win_row/win_col/win_dir - anchor and direction of the winning line.
module c4_win_scanner
    import connect4_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic [ROWS-1:0][COLS-1:0][1:0]     board,
    output logic                               busy,
    output logic                               done,
    output logic                               win,
    output logic [1:0]                         winner,
    output logic                               draw,
    output logic [2:0]                         win_row,
    output logic [2:0]                         win_col,
    output logic [1:0]                         win_dir
);

    state_t             state_q, state_d;
    board_t             snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RC_W-1:0]    row_q, row_d;
    logic [RC_W-1:0]    col_q, col_d;
    logic               busy_d, done_d, win_d, draw_d;
    logic [1:0]         winner_d, win_dir_d;
    logic [2:0]         win_row_d, win_col_d;

    logic [1:0]         line_cells [NUM_DIRS][WIN_LEN];
    logic               dir_valid  [NUM_DIRS];
    logic [NUM_DIRS-1:0] dir_match_c;
    logic [1:0]         dir_code_c [NUM_DIRS];
    logic               hit_c;
    logic [1:0]         hit_code_c;
    logic [1:0]         hit_dir_c;
    logic               board_full_c;

    // Gather the four cells of each direction starting at the current anchor.
    always_comb begin
        for (int d = 0; d < int'(NUM_DIRS); d++) begin
            dir_valid[d] = 1'b1;
            for (int k = 0; k < int'(WIN_LEN); k++) begin
                if (!in_board(int'(row_q) + k * dir_dr(d), int'(col_q) + k * dir_dc(d)))
                    dir_valid[d] = 1'b0;
                line_cells[d][k] = cell_at(snap_q,
                                           int'(row_q) + k * dir_dr(d),
                                           int'(col_q) + k * dir_dc(d));
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_DIRS); g++) begin : g_dir
        c4_line_match u_match (
            .cell0   (line_cells[g][0]),
            .cell1   (line_cells[g][1]),
            .cell2   (line_cells[g][2]),
            .cell3   (line_cells[g][3]),
            .valid   (dir_valid[g]),
            .match_c (dir_match_c[g]),
            .code_c  (dir_code_c[g])
        );
    end

    // Lowest direction index wins within an anchor (H > V > D > AD).
    always_comb begin
        hit_c      = 1'b0;
        hit_code_c = 2'(CELL_EMPTY);
        hit_dir_c  = 2'(DIR_H);
        for (int d = int'(NUM_DIRS) - 1; d >= 0; d--) begin
            if (dir_match_c[d]) begin
                hit_c      = 1'b1;
                hit_code_c = dir_code_c[d];
                hit_dir_c  = 2'(d);
            end
        end
    end

    // Empty and invalid cells both count as unfilled for the draw decision.
    always_comb begin
        board_full_c = 1'b1;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (!((snap_q[r][c] == 2'(CELL_P1)) || (snap_q[r][c] == 2'(CELL_P2))))
                    board_full_c = 1'b0;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        busy_d    = busy;
        done_d    = 1'b0;
        win_d     = win;
        winner_d  = winner;
        draw_d    = draw;
        win_row_d = win_row;
        win_col_d = win_col;
        win_dir_d = win_dir;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d    = board;
                    idx_d     = '0;
                    row_d     = '0;
                    col_d     = '0;
                    busy_d    = 1'b1;
                    win_d     = 1'b0;
                    winner_d  = '0;
                    draw_d    = 1'b0;
                    win_row_d = '0;
                    win_col_d = '0;
                    win_dir_d = '0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (hit_c) begin
                    win_d     = 1'b1;
                    winner_d  = hit_code_c;
                    win_row_d = row_q;
                    win_col_d = col_q;
                    win_dir_d = hit_dir_c;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end else if (idx_q == IDX_W'(CELLS - 1)) begin
                    draw_d  = board_full_c;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (col_q == RC_W'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + RC_W'(1);
                    end else begin
                        col_d = col_q + RC_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            win     <= 1'b0;
            winner  <= '0;
            draw    <= 1'b0;
            win_row <= '0;
            win_col <= '0;
            win_dir <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy    <= busy_d;
            done    <= done_d;
            win     <= win_d;
            winner  <= winner_d;
            draw    <= draw_d;
            win_row <= win_row_d;
            win_col <= win_col_d;
            win_dir <= win_dir_d;
        end
    end

endmodule

// File: tb/tb_c4_win_scanner.sv
// Self-checking bench for c4_win_scanner: directed vector table, hand-written
// multi-cycle sequences and randomized boards checked against a rule-level model.
module tb_c4_win_scanner;
    import connect4_pkg::*;

    logic                           clk = 1'b0;
    logic                           reset_n;
    logic                           start;
    logic [ROWS-1:0][COLS-1:0][1:0] board;
    logic                           busy, done, win, draw;
    logic [1:0]                     winner, win_dir;
    logic [2:0]                     win_row, win_col;

    int checks   = 0;
    int failures = 0;
    int bm [ROWS][COLS];

    typedef struct {
        int code; int r; int c; int dr; int dc; int len;
        int e_win; int e_who; int e_row; int e_col; int e_dir; int e_draw; int e_lat;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    c4_win_scanner dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .board   (board),
        .busy    (busy),
        .done    (done),
        .win     (win),
        .winner  (winner),
        .draw    (draw),
        .win_row (win_row),
        .win_col (win_col),
        .win_dir (win_dir)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                bm[r][c] = 0;
    endtask

    task automatic place(input int code, input int r, input int c,
                         input int dr, input int dc, input int len);
        for (int k = 0; k < len; k++)
            bm[r + k * dr][c + k * dc] = code;
    endtask

    // Full board whose longest run in any direction is two.
    task automatic fill_draw();
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                bm[r][c] = 1 + (((c / 2) % 2) ^ (r % 2));
    endtask

    task automatic apply_board();
        for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(COLS); c++)
                board[r][c] = 2'(bm[r][c]);
    endtask

    // Reference: walk anchors in reading order, first player-owned line of four wins.
    task automatic model(output int w, output int who, output int row, output int col,
                         output int dir, output int drw, output int lat);
        int drs [4];
        int dcs [4];
        drs = '{0, 1, 1, 1};
        dcs = '{1, 0, 1, -1};
        w = 0; who = 0; row = 0; col = 0; dir = 0; drw = 0;
        lat = ROWS * COLS + 1;
        for (int i = 0; i < int'(ROWS * COLS) && w == 0; i++) begin
            int r0, c0;
            r0 = i / int'(COLS);
            c0 = i % int'(COLS);
            for (int d = 0; d < 4 && w == 0; d++) begin
                int re, ce;
                re = r0 + 3 * drs[d];
                ce = c0 + 3 * dcs[d];
                if (re < int'(ROWS) && ce >= 0 && ce < int'(COLS)) begin
                    int v;
                    v = bm[r0][c0];
                    if ((v == 1 || v == 2) &&
                        bm[r0 + drs[d]][c0 + dcs[d]] == v &&
                        bm[r0 + 2 * drs[d]][c0 + 2 * dcs[d]] == v &&
                        bm[re][ce] == v) begin
                        w = 1; who = v; row = r0; col = c0; dir = d; lat = i + 2;
                    end
                end
            end
        end
        if (w == 0) begin
            drw = 1;
            for (int r = 0; r < int'(ROWS); r++)
                for (int c = 0; c < int'(COLS); c++)
                    if (bm[r][c] != 1 && bm[r][c] != 2) drw = 0;
        end
    endtask

    // Start a scan, optionally re-pulse start or wipe the board mid-scan, then check result.
    task automatic run_and_check(input string tag, input int e_win, input int e_who,
                                 input int e_row, input int e_col, input int e_dir,
                                 input int e_draw, input int e_lat,
                                 input int restart_at, input int clear_at);
        int n;
        int extra;
        apply_board();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("%s.busy_start", tag), int'(busy), 1);
        n = 0;
        for (int e = 1; e <= 100; e++) begin
            if (e == restart_at) start = 1'b1;
            if (e == clear_at)   board = '0;
            @(posedge clk); #1;
            start = 1'b0;
            n = e;
            if (done) break;
            if (e == 100) n = 101;
        end
        check($sformatf("%s.latency", tag), n, e_lat);
        check($sformatf("%s.win", tag), int'(win), e_win);
        check($sformatf("%s.winner", tag), int'(winner), e_who);
        check($sformatf("%s.win_row", tag), int'(win_row), e_row);
        check($sformatf("%s.win_col", tag), int'(win_col), e_col);
        check($sformatf("%s.win_dir", tag), int'(win_dir), e_dir);
        check($sformatf("%s.draw", tag), int'(draw), e_draw);
        check($sformatf("%s.busy_done", tag), int'(busy), 0);
        extra = 0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check($sformatf("%s.extra_done", tag), extra, 0);
        check($sformatf("%s.win_held", tag), int'(win), e_win);
        check($sformatf("%s.winner_held", tag), int'(winner), e_who);
    endtask

    task automatic run_model(input string tag);
        int w, who, row, col, dir, drw, lat;
        model(w, who, row, col, dir, drw, lat);
        run_and_check(tag, w, who, row, col, dir, drw, lat, 0, 0);
    endtask

    initial begin
        int extra;
        reset_n = 1'b0;
        start   = 1'b0;
        board   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.win", int'(win), 0);
        check("reset.winner", int'(winner), 0);
        check("reset.draw", int'(draw), 0);
        check("reset.win_row", int'(win_row), 0);
        check("reset.win_col", int'(win_col), 0);
        check("reset.win_dir", int'(win_dir), 0);
        reset_n = 1'b1;

        //           code r  c  dr dc len  win who row col dir draw lat
        vecs[0] = '{0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 43};
        vecs[1] = '{1, 2, 1, 0, 1, 4,   1, 1, 2, 1, 0, 0, 17};
        vecs[2] = '{2, 1, 5, 1, 0, 4,   1, 2, 1, 5, 1, 0, 14};
        vecs[3] = '{1, 0, 6, 1, -1, 4,  1, 1, 0, 6, 3, 0, 8};
        vecs[4] = '{2, 2, 3, 1, 1, 4,   1, 2, 2, 3, 2, 0, 19};
        vecs[5] = '{1, 5, 3, 0, 1, 4,   1, 1, 5, 3, 0, 0, 40};
        vecs[6] = '{1, 2, 0, 1, 0, 4,   1, 1, 2, 0, 1, 0, 16};
        vecs[7] = '{3, 0, 0, 0, 1, 4,   0, 0, 0, 0, 0, 0, 43};
        vecs[8] = '{2, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0, 0, 43};
        vecs[9] = '{2, 2, 6, 1, -1, 4,  1, 2, 2, 6, 3, 0, 22};

        for (int i = 0; i < 10; i++) begin
            clear_model();
            place(vecs[i].code, vecs[i].r, vecs[i].c, vecs[i].dr, vecs[i].dc, vecs[i].len);
            run_and_check($sformatf("vec%0d", i), vecs[i].e_win, vecs[i].e_who,
                          vecs[i].e_row, vecs[i].e_col, vecs[i].e_dir,
                          vecs[i].e_draw, vecs[i].e_lat, 0, 0);
        end

        // Same anchor carries horizontal and vertical lines: horizontal reported.
        clear_model();
        place(1, 0, 0, 0, 1, 4);
        place(1, 0, 0, 1, 0, 4);
        run_and_check("priority", 1, 1, 0, 0, 0, 0, 2, 0, 0);

        // Full board without any line, then the same board with one invalid cell.
        clear_model();
        fill_draw();
        run_and_check("draw_full", 0, 0, 0, 0, 0, 1, 43, 0, 0);
        run_model("draw_model");
        bm[3][3] = 3;
        run_and_check("draw_bad_cell", 0, 0, 0, 0, 0, 0, 43, 0, 0);

        // Start re-pulsed mid-scan, and board wiped mid-scan.
        clear_model();
        place(1, 2, 1, 0, 1, 4);
        run_and_check("restart_ignored", 1, 1, 2, 1, 0, 0, 17, 5, 0);
        run_and_check("snapshot_kept", 1, 1, 2, 1, 0, 0, 17, 0, 3);

        // Reset at edge 10 aborts the scan.
        clear_model();
        place(2, 2, 1, 0, 1, 4);
        apply_board();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort.busy_before", int'(busy), 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort.busy", int'(busy), 0);
        check("abort.done", int'(done), 0);
        check("abort.win", int'(win), 0);
        check("abort.winner", int'(winner), 0);
        check("abort.draw", int'(draw), 0);
        check("abort.win_row", int'(win_row), 0);
        check("abort.win_col", int'(win_col), 0);
        check("abort.win_dir", int'(win_dir), 0);
        extra = 0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        check("abort.quiet", extra, 0);

        // Randomized boards against the model.
        for (int t = 0; t < 24; t++) begin
            int muts;
            clear_model();
            if ($urandom_range(0, 1) == 1) fill_draw();
            muts = int'($urandom_range(1, 8));
            for (int m = 0; m < muts; m++)
                bm[$urandom_range(0, ROWS - 1)][$urandom_range(0, COLS - 1)] =
                    int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                int d, r, c, dr, dc;
                d  = int'($urandom_range(0, 3));
                dr = (d == 0) ? 0 : 1;
                dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                r  = (dr == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 5));
                if (dc == 1)       c = int'($urandom_range(0, 3));
                else if (dc == -1) c = int'($urandom_range(3, 6));
                else               c = int'($urandom_range(0, 6));
                place(int'($urandom_range(1, 2)), r, c, dr, dc, 4);
            end
            run_model($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/c4_win_scanner.md
Name: c4_win_scanner

Overview:
- Sequential reader of the Connect-4 board array maintained by the game FSM.
- On a start pulse it snapshots the board and scans it one anchor cell per clock.
- It reports the first four-in-a-line found, or a draw (board full, no win), and drives the FSM's win_detected input.
- Sits between the game FSM (board writer) and the FSM's win/draw inputs, in the VGA_CLK domain.

Parameters:
- ROWS, 6, board rows.
- COLS, 7, board columns.
- WIN_LEN, 4, run length that counts as a win.

Ports:
- clk  input  1  system clock (VGA_CLK domain).
- reset_n  input  1  reset; synchronous, active-low.
- start  input  1  one-cycle request to scan the current board.
- board  input  [ROWS][COLS]x2  cell codes: 0 empty, 1 player 1, 2 player 2, 3 invalid.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- win  output  1  a line was found.
- winner  output  2  cell code of the winning line (1 or 2); 0 if no win.
- draw  output  1  board full and no win.
- win_row  output  3  row of the winning line's anchor.
- win_col  output  3  column of the winning line's anchor.
- win_dir  output  2  0 horizontal (c+), 1 vertical (r+), 2 diagonal (r+,c+), 3 anti-diagonal (r+,c-).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, win, draw = 0; winner, win_row, win_col, win_dir = 0.
  - Reset mid-scan aborts the scan; no done pulse is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 copies board into an internal snapshot, clears idx and all result outputs, sets busy=1, and moves to SCAN.
- SCAN:
  - Each cycle evaluates anchor idx = r*COLS + c, in order 0..ROWS*COLS-1, for all 4 directions in parallel.
  - A direction is valid only if all WIN_LEN cells lie inside the board (horizontal c+3<=6; vertical r+3<=5; diagonal both; anti-diagonal r+3<=5 and c>=3).
  - A match requires all 4 cells equal and the code to be 1 or 2. Code 3 never matches.
  - First match (lowest idx; within one anchor, priority H > V > D > AD):
    - latch win=1, winner, win_row=r, win_col=c, win_dir;
    - go to DONE.
  - After idx = ROWS*COLS-1 with no match:
    - draw=1 iff every snapshot cell is 1 or 2 (code 0 or 3 counts as not filled);
    - go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Result outputs hold their values until the next accepted start.
- Latency, counted from the edge that samples start:
  - match at anchor i: done is high after edge i+2;
  - no match: done is high after edge ROWS*COLS+1 (43 edges).
- start while busy or in DONE is ignored.
- Board changes after the snapshot have no effect on the running scan.
- Row and column counters wrap together: c rolls from COLS-1 to 0 and increments r; idx never exceeds ROWS*COLS-1.

Decomposition:
- connect4_pkg holds:
  - ROWS, COLS, WIN_LEN;
  - cell_t enum (CELL_EMPTY=0, CELL_P1=1, CELL_P2=2, CELL_BAD=3);
  - dir_t enum (DIR_H, DIR_V, DIR_D, DIR_AD);
  - state_t.
- One combinational sub-module, c4_line_match: takes 4 cell codes and a valid bit, returns match and cell code. Instantiated 4 times, once per direction.

Test Plan:
- All-empty board, start -> done 43 edges after start; win=0, draw=0, winner=0.
- P1 at row 2, cols 1..4 -> win=1, winner=1, win_row=2, win_col=1, win_dir=0; done at edge 17 (idx 15).
- P2 at col 5, rows 1..4 -> win=1, winner=2, win_row=1, win_col=5, win_dir=1.
- P1 at (0,6),(1,5),(2,4),(3,3) -> win_dir=3, win_row=0, win_col=6.
- Priority case: the same anchor (0,0) holds both a horizontal and a vertical P1 line -> win_dir=0.
- Full board with no line, checked against a bench model -> draw=1, win=0 at edge 43.
- Same full board with one cell set to 3 -> draw=0.
- Robustness:
  - start pulsed again at edge 5 of a scan -> ignored, single done pulse;
  - board cleared to empty mid-scan -> result still reflects the snapshot;
  - reset_n=0 at edge 10 -> no done pulse, all outputs 0.
